// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus word, RAM handshake state and
// arbitration FSM state.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and RAM-side signals around the arbiter.
// The arb modport is the arbiter's view; tb drives requests and the RAM side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data accesses. Data wins
// arbitration unless the instruction side has waited STARVE_MAX data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  mem_arbiter_if.arb bus
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             err_q;
  logic             set_err;
  logic             d_req;

  assign d_req      = bus.dREN | bus.dWEN;
  assign bus.ramerr = err_q;

  always_comb begin
    next_state   = state;
    next_cnt     = starve_cnt;
    set_err      = 1'b0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    unique case (state)
      IDLE: begin
        // Data is granted unless the fetch side has hit its starvation bound.
        if (d_req && !(bus.iREN && starve_cnt == CNT_MAX)) begin
          next_state = D_ACC;
          next_cnt   = bus.iREN ? starve_cnt + 1'b1 : '0;
        end else if (bus.iREN) begin
          next_state = I_ACC;
          next_cnt   = '0;
        end else begin
          next_cnt   = '0;
        end
      end

      I_ACC: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          case (bus.ramstate)
            ACCESS: begin
              bus.iwait  = 1'b0;
              bus.iload  = bus.ramload;
              next_state = IDLE;
            end
            ERROR: begin
              set_err    = 1'b1;
              next_state = IDLE;
            end
            default: next_state = I_ACC;
          endcase
        end
      end

      D_ACC: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          case (bus.ramstate)
            ACCESS: begin
              bus.dwait  = 1'b0;
              bus.dload  = bus.ramload;
              next_state = IDLE;
            end
            ERROR: begin
              set_err    = 1'b1;
              next_state = IDLE;
            end
            default: next_state = D_ACC;
          endcase
        end
      end

      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      if (set_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, contention, starvation
// bound, error retry, withdrawal and reset during an access.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramerr} !== 5'b11000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b want 11000", c,
                 {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramerr});
      end
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    nrst = 1'b1;
    step();
    n_cmp++;
    if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'h0) begin
      n_fail++;
      $display("FAIL idle_zero_buses: got %h want 0",
               {bus.ramaddr, bus.ramstore, bus.iload, bus.dload});
    end
  endtask

  task automatic test_i_only();
    bus.iREN = 1'b1;
    bus.iaddr = 32'h40;
    bus.ramstate = FREE;
    #1;
    n_cmp++;
    if ({bus.iwait, bus.ramREN} !== 2'b10) begin
      n_fail++;
      $display("FAIL i_only_arb_cycle: got %b want 10", {bus.iwait, bus.ramREN});
    end
    step();
    bus.ramstate = ACCESS;
    bus.ramload = 32'h8C220004;
    #1;
    n_cmp++;
    if ({bus.ramREN, bus.iwait, bus.dwait} !== 3'b101 || bus.ramaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL i_only_access: got ren/iw/dw %b addr %h want 101 addr 40",
               {bus.ramREN, bus.iwait, bus.dwait}, bus.ramaddr);
    end
    n_cmp++;
    if (bus.iload !== 32'h8C220004) begin
      n_fail++;
      $display("FAIL i_only_load: got %h want 8c220004", bus.iload);
    end
    step();
    bus.iREN = 1'b0;
    bus.ramstate = FREE;
    #1;
    n_cmp++;
    if ({bus.iwait, bus.ramREN} !== 2'b10 || bus.iload !== 32'h0) begin
      n_fail++;
      $display("FAIL i_only_after: got iw/ren %b load %h want 10 load 0",
               {bus.iwait, bus.ramREN}, bus.iload);
    end
  endtask

  task automatic test_contention();
    bus.iREN = 1'b1;
    bus.iaddr = 32'h80;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    bus.ramstate = FREE;
    step();
    n_cmp++;
    if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b1011 ||
        bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL contention_d_first: got wen/ren/dw/iw %b addr %h st %h want 1011 100 deadbeef",
               {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait}, bus.ramaddr, bus.ramstore);
    end
    bus.ramstate = ACCESS;
    #1;
    n_cmp++;
    if ({bus.dwait, bus.iwait} !== 2'b01) begin
      n_fail++;
      $display("FAIL contention_d_done: got dw/iw %b want 01", {bus.dwait, bus.iwait});
    end
    step();
    bus.dWEN = 1'b0;
    bus.ramstate = FREE;
    step();
    bus.ramload = 32'h11112222;
    n_cmp++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b10 || bus.ramaddr !== 32'h80) begin
      n_fail++;
      $display("FAIL contention_i_next: got ren/wen %b addr %h want 10 addr 80",
               {bus.ramREN, bus.ramWEN}, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    #1;
    n_cmp++;
    if (bus.iwait !== 1'b0 || bus.iload !== 32'h11112222) begin
      n_fail++;
      $display("FAIL contention_i_done: got iw %b load %h want 0 11112222", bus.iwait, bus.iload);
    end
    step();
    bus.iREN = 1'b0;
    bus.ramstate = FREE;
  endtask

  task automatic test_starvation();
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    bus.ramstate = ACCESS;
    bus.ramload = 32'h00001234;
    for (int n = 0; n < 10; n++) begin
      step();
      n_cmp++;
      if ((n % 5) == 4) begin
        if ({bus.iwait, bus.dwait} !== 2'b01) begin
          n_fail++;
          $display("FAIL starve_grant %0d: got iw/dw %b want 01", n, {bus.iwait, bus.dwait});
        end
      end else begin
        if ({bus.iwait, bus.dwait} !== 2'b10) begin
          n_fail++;
          $display("FAIL starve_grant %0d: got iw/dw %b want 10", n, {bus.iwait, bus.dwait});
        end
      end
      n_cmp++;
      if (bus.ramREN && bus.ramWEN) begin
        n_fail++;
        $display("FAIL starve_strobes %0d: got both strobes high want exclusive", n);
      end
      step();
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.ramstate = FREE;
  endtask

  task automatic test_error();
    bus.dREN = 1'b1;
    bus.daddr = 32'h200;
    bus.ramstate = ERROR;
    step();
    n_cmp++;
    if ({bus.dwait, bus.ramREN, bus.ramerr} !== 3'b110 || bus.dload !== 32'h0) begin
      n_fail++;
      $display("FAIL error_cycle: got dw/ren/err %b load %h want 110 load 0",
               {bus.dwait, bus.ramREN, bus.ramerr}, bus.dload);
    end
    step();
    n_cmp++;
    if ({bus.ramerr, bus.ramREN, bus.dwait} !== 3'b101) begin
      n_fail++;
      $display("FAIL error_sticky_idle: got err/ren/dw %b want 101",
               {bus.ramerr, bus.ramREN, bus.dwait});
    end
    bus.ramstate = ACCESS;
    bus.ramload = 32'hCAFEF00D;
    step();
    n_cmp++;
    if (bus.dwait !== 1'b0 || bus.dload !== 32'hCAFEF00D || bus.ramaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL error_retry: got dw %b load %h addr %h want 0 cafef00d 200",
               bus.dwait, bus.dload, bus.ramaddr);
    end
    step();
    bus.dREN = 1'b0;
    bus.ramstate = FREE;
    #1;
    n_cmp++;
    if (bus.ramerr !== 1'b1) begin
      n_fail++;
      $display("FAIL error_still_set: got %b want 1", bus.ramerr);
    end
  endtask

  task automatic test_withdraw_reset();
    bus.dREN = 1'b1;
    bus.daddr = 32'h300;
    bus.ramstate = BUSY;
    step();
    step();
    n_cmp++;
    if ({bus.ramREN, bus.dwait} !== 2'b11 || bus.ramaddr !== 32'h300) begin
      n_fail++;
      $display("FAIL busy_hold: got ren/dw %b addr %h want 11 addr 300",
               {bus.ramREN, bus.dwait}, bus.ramaddr);
    end
    bus.dREN = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ramREN, bus.dwait} !== 2'b01) begin
      n_fail++;
      $display("FAIL withdraw_drop: got ren/dw %b want 01", {bus.ramREN, bus.dwait});
    end
    step();
    bus.dREN = 1'b1;
    #1;
    n_cmp++;
    if (bus.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_to_idle: got ramREN %b want 0", bus.ramREN);
    end
    bus.dREN = 1'b0;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h44;
    step();
    n_cmp++;
    if ({bus.ramREN, bus.iwait} !== 2'b11 || bus.ramaddr !== 32'h44) begin
      n_fail++;
      $display("FAIL reset_pre_iacc: got ren/iw %b addr %h want 11 addr 44",
               {bus.ramREN, bus.iwait}, bus.ramaddr);
    end
    nrst = 1'b0;
    step();
    bus.ramstate = ACCESS;
    #1;
    n_cmp++;
    if ({bus.iwait, bus.ramREN, bus.ramerr} !== 3'b100 || bus.iload !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_access: got iw/ren/err %b load %h want 100 load 0",
               {bus.iwait, bus.ramREN, bus.ramerr}, bus.iload);
    end
    nrst = 1'b1;
    bus.iREN = 1'b0;
    bus.ramstate = FREE;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    nrst = 1'b0;
    bus.iREN = 1'b0;
    bus.iaddr = '0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ramload = '0;
    bus.ramstate = FREE;
    test_reset();
    test_i_only();
    test_contention();
    test_starvation();
    test_error();
    test_withdraw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
